// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_pkg
//  Description : Shared types and constants for the staged reset sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int c_rst_count_w    = 8;
    localparam int c_req_filter_len = 3;

endpackage : rst_seq_pkg
`default_nettype wire

// File: rtl/rst_req_filter.sv
`default_nettype none
// ============================================================================
//  Module      : rst_req_filter
//  Description : Turns the software reset request level into a one-cycle
//                accept pulse. RST_SEQ_REQ_FILTER_EN selects the 3-sample
//                qualifier; otherwise a plain rising-edge detect is used.
//  Revision    : 1.0  initial release
// ============================================================================
module rst_req_filter
    import rst_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sw_rst_req,
    output logic accept
);

`ifdef RST_SEQ_REQ_FILTER_EN
    logic [c_req_filter_len-1:0] r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[c_req_filter_len-2:0], sw_rst_req};
        end
    end

    // Accept on the third consecutive high sample only; the oldest sample
    // being low makes a held request fire exactly once.
    assign accept = sw_rst_req & (&r_hist[c_req_filter_len-2:0])
                    & ~r_hist[c_req_filter_len-1];
`else
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= sw_rst_req;
        end
    end

    assign accept = sw_rst_req & ~r_prev;
`endif

endmodule : rst_req_filter
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Asserts all reset outputs, holds them HOLD_CYCLES, then
//                releases them in index order every STAGE_GAP cycles.
//                Request qualification depends on RST_SEQ_REQ_FILTER_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sw_rst_req,
    output logic [NUM_OUT-1:0]       rst_out,
    output logic                     rst_done,
    output logic                     busy,
    output logic [c_rst_count_w-1:0] rst_count
);

    localparam int c_cnt_max = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [NUM_OUT-1:0] c_last_bit = NUM_OUT'(1) << (NUM_OUT - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_cnt_w-1:0]       w_cnt_nxt;
    logic [NUM_OUT-1:0]       r_rst_out;
    logic [NUM_OUT-1:0]       w_rst_out_nxt;
    logic                     r_rst_done;
    logic                     r_busy;
    logic [c_rst_count_w-1:0] r_rst_count;
    logic                     w_accept;
    logic                     w_hold_end;
    logic                     w_gap_end;

    rst_req_filter u_req_filter (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
        .accept     (w_accept)
    );

    assign w_hold_end = (r_cnt == c_cnt_w'(HOLD_CYCLES - 1));
    assign w_gap_end  = (r_cnt == c_cnt_w'(STAGE_GAP - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (w_accept) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_hold_end) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (NUM_OUT == 1) ? RUN : RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_gap_end) begin
                        w_cnt_nxt = '0;
                        if (r_rst_out == c_last_bit) begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                RUN:     w_cnt_nxt = r_cnt;
                default: begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Shifting left drops the lowest still-asserted bit, giving index order.
    always_comb begin
        w_rst_out_nxt = r_rst_out;
        if (w_accept) begin
            w_rst_out_nxt = '1;
        end else if (((r_state == HOLD) && w_hold_end) ||
                     ((r_state == RELEASE) && w_gap_end)) begin
            w_rst_out_nxt = r_rst_out << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_out   <= '1;
            r_rst_done  <= 1'b0;
            r_busy      <= 1'b1;
            r_rst_count <= '0;
        end else begin
            r_rst_out  <= w_rst_out_nxt;
            r_rst_done <= (w_state_nxt == RUN);
            r_busy     <= (w_state_nxt != RUN);
            if (w_accept && (r_rst_count != '1)) begin
                r_rst_count <= r_rst_count + 1'b1;
            end
        end
    end

    assign rst_out   = r_rst_out;
    assign rst_done  = r_rst_done;
    assign busy      = r_busy;
    assign rst_count = r_rst_count;

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Directed self-checking bench for reset_sequencer, default
//                parameters plus a NUM_OUT=1 / HOLD_CYCLES=1 instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

`ifdef RST_SEQ_REQ_FILTER_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] rst_out;
    logic       rst_done;
    logic       busy;
    logic [7:0] rst_count;

    logic       reset2 = 1'b1;
    logic       sw_rst_req2 = 1'b0;
    logic [0:0] rst_out2;
    logic       rst_done2;
    logic       busy2;
    logic [7:0] rst_count2;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_OUT(4), .HOLD_CYCLES(16), .STAGE_GAP(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .rst_done   (rst_done),
        .busy       (busy),
        .rst_count  (rst_count)
    );

    reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .STAGE_GAP(4)) u_dut1 (
        .clk        (clk),
        .reset      (reset2),
        .sw_rst_req (sw_rst_req2),
        .rst_out    (rst_out2),
        .rst_done   (rst_done2),
        .busy       (busy2),
        .rst_count  (rst_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise the request long enough to be accepted on the last edge stepped.
    task automatic do_req();
        sw_rst_req = 1'b1;
        step(c_lat + 1);
        sw_rst_req = 1'b0;
        if (exp_cnt < 255) exp_cnt++;
    endtask

    initial begin
        // Power-on: reset high for three edges.
        step(3);
        check("reset_rst_out", rst_out, 4'b1111);
        check("reset_done", rst_done, 0);
        check("reset_busy", busy, 1);
        check("reset_count", rst_count, 0);
        reset = 1'b0;
        step(15);
        check("por_E15", rst_out, 4'b1111);
        step(1);
        check("por_E16", rst_out, 4'b1110);
        step(4);
        check("por_E20", rst_out, 4'b1100);
        step(4);
        check("por_E24", rst_out, 4'b1000);
        check("por_E24_done", rst_done, 0);
        step(4);
        check("por_E28", rst_out, 4'b0000);
        check("por_E28_done", rst_done, 1);
        check("por_E28_busy", busy, 0);
        step(3);
        check("run_stable", rst_out, 4'b0000);

        // Request in RUN.
        do_req();
        check("req_rst_out", rst_out, 4'b1111);
        check("req_busy", busy, 1);
        check("req_done", rst_done, 0);
        check("req_count", rst_count, exp_cnt);
        step(15);
        check("req_k15", rst_out, 4'b1111);
        step(1);
        check("req_k16", rst_out, 4'b1110);
        step(4);
        check("req_k20", rst_out, 4'b1100);

        // Request mid-RELEASE restarts the full sequence.
        do_req();
        check("mid_rst_out", rst_out, 4'b1111);
        check("mid_count", rst_count, exp_cnt);
        step(15);
        check("mid_k15", rst_out, 4'b1111);
        step(1);
        check("mid_k16", rst_out, 4'b1110);
        step(12);
        check("mid_done", rst_done, 1);
        check("mid_out0", rst_out, 4'b0000);

`ifdef RST_SEQ_REQ_FILTER_EN
        sw_rst_req = 1'b1;
        step(2);
        sw_rst_req = 1'b0;
        step(3);
        check("pulse2_out", rst_out, 4'b0000);
        check("pulse2_count", rst_count, exp_cnt);
        sw_rst_req = 1'b1;
        step(2);
        check("held_pre", rst_out, 4'b0000);
        step(1);
        exp_cnt++;
        check("held_accept", rst_out, 4'b1111);
        check("held_count", rst_count, exp_cnt);
        step(7);
        sw_rst_req = 1'b0;
        check("held_once", rst_count, exp_cnt);
        step(21);
`else
        sw_rst_req = 1'b1;
        step(1);
        exp_cnt++;
        check("held_accept", rst_out, 4'b1111);
        check("held_count", rst_count, exp_cnt);
        step(9);
        sw_rst_req = 1'b0;
        check("held_once", rst_count, exp_cnt);
        step(19);
`endif
        check("held_done", rst_done, 1);

        // Saturation.
        for (int i = 0; i < 260; i++) begin
            do_req();
            step(1);
        end
        check("sat_count", rst_count, 255);
        check("sat_model", rst_count, exp_cnt);

        // Reset has priority over a simultaneous request.
        reset = 1'b1;
        sw_rst_req = 1'b1;
        step(1);
        check("prio_rst_out", rst_out, 4'b1111);
        check("prio_busy", busy, 1);
        check("prio_count", rst_count, 0);
        sw_rst_req = 1'b0;
        step(1);
        reset = 1'b0;

        // Single output, one-cycle hold.
        sw_rst_req2 = 1'b1;
        step(1);
        check("one_rst_out", rst_out2, 1'b1);
        check("one_done", rst_done2, 0);
        check("one_count", rst_count2, 0);
        sw_rst_req2 = 1'b0;
        step(1);
        reset2 = 1'b0;
        step(1);
        check("one_E1_out", rst_out2, 1'b0);
        check("one_E1_done", rst_done2, 1);
        check("one_E1_busy", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
